// File: rtl/uart_frame_pkg.sv
// Shared types and checksum helper for the UART command framer.
// Build option UART_FRAME_CHKSUM_EN adds a trailing checksum byte on both paths.
package uart_frame_pkg;

   typedef enum logic {
      RX_IDLE,
      RX_COLLECT
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SEND,
      TX_WAIT
   } tx_state_t;

   localparam logic [7:0] CHK_INIT = 8'h00;

   function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/resp_serializer.sv
// Response serializer: latches a RESP_BYTES word and sends it MSB byte first.
// With UART_FRAME_CHKSUM_EN a negated-sum checksum byte follows the last resp byte.
//
// state   | meaning
// TX_IDLE | waiting for trmt, resp_busy low
// TX_SEND | presenting current byte, uart_trmt high for this cycle
// TX_WAIT | waiting for uart_tx_done of the current byte
module resp_serializer
   import uart_frame_pkg::*;
#(
   parameter int RESP_BYTES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [8*RESP_BYTES-1:0] resp,
   input  logic                    trmt,
   output logic [7:0]              uart_tx_data,
   output logic                    uart_trmt,
   input  logic                    uart_tx_done,
   output logic                    resp_busy,
   output logic                    resp_done
);

`ifdef UART_FRAME_CHKSUM_EN
   localparam int TX_BYTES = RESP_BYTES + 1;
`else
   localparam int TX_BYTES = RESP_BYTES;
`endif
   localparam int IDX_W = $clog2(TX_BYTES) + 1;
   localparam int TW    = 8*TX_BYTES;

   tx_state_t        state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [TW-1:0]    tx_q, tx_load;
   logic             load, advance, done_nxt;

`ifdef UART_FRAME_CHKSUM_EN
   logic [7:0] resp_sum;

   always_comb begin
      resp_sum = CHK_INIT;
      for (int i = 0; i < RESP_BYTES; i++) begin
         resp_sum = chk_add(resp_sum, resp[8*i +: 8]);
      end
   end

   assign tx_load = {resp, ~resp_sum + 8'd1};
`else
   assign tx_load = resp;
`endif

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      load      = 1'b0;
      advance   = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         TX_IDLE: begin
            if (trmt) begin
               load      = 1'b1;
               idx_nxt   = '0;
               state_nxt = TX_SEND;
            end
         end
         TX_SEND: state_nxt = TX_WAIT;
         TX_WAIT: begin
            if (uart_tx_done) begin
               if (idx == IDX_W'(TX_BYTES-1)) begin
                  done_nxt  = 1'b1;
                  state_nxt = TX_IDLE;
               end else begin
                  advance   = 1'b1;
                  idx_nxt   = idx + IDX_W'(1);
                  state_nxt = TX_SEND;
               end
            end
         end
         default: state_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= TX_IDLE;
         idx       <= '0;
         tx_q      <= '0;
         resp_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         resp_done <= done_nxt;
         if (load) begin
            tx_q <= tx_load;
         end else if (advance) begin
            tx_q <= tx_q << 8;
         end
      end
   end

   // the byte on air is always the top byte of the latched shift register
   assign uart_tx_data = tx_q[TW-1 -: 8];
   assign uart_trmt    = (state == TX_SEND);
   assign resp_busy    = (state != TX_IDLE);

endmodule

// File: rtl/uart_cmd_framer.sv
// Byte framer between UART and command processor: assembles commands, flags
// timeouts/overruns, serialises responses. UART_FRAME_CHKSUM_EN adds checksums.
//
// state      | meaning
// RX_IDLE    | no partial frame, next byte starts a command
// RX_COLLECT | partial frame held, timeout counter running
module uart_cmd_framer
   import uart_frame_pkg::*;
#(
   parameter int CMD_BYTES   = 2,
   parameter int RESP_BYTES  = 1,
   parameter int TIMEOUT_CYC = 0,
   parameter int TMO_W       = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              rx_data,
   input  logic                    rx_rdy,
   output logic                    clr_rx_rdy,
   output logic [8*CMD_BYTES-1:0]  cmd,
   output logic                    cmd_rdy,
   input  logic                    clr_cmd_rdy,
   output logic                    overrun,
   output logic                    frame_err,
   input  logic [8*RESP_BYTES-1:0] resp,
   input  logic                    trmt,
   output logic [7:0]              uart_tx_data,
   output logic                    uart_trmt,
   input  logic                    uart_tx_done,
   output logic                    resp_busy,
   output logic                    resp_done
);

`ifdef UART_FRAME_CHKSUM_EN
   localparam int FRAME_BYTES = CMD_BYTES + 1;
`else
   localparam int FRAME_BYTES = CMD_BYTES;
`endif
   localparam int CNT_W = $clog2(FRAME_BYTES + 1);
   localparam int CW    = 8*CMD_BYTES;

   rx_state_t        rx_state, rx_state_nxt;
   logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
   logic [CW-1:0]    shift_q, shift_nxt, cmd_nxt;
   logic             fin, complete, chk_bad, tmo_hit;

   assign shift_nxt = (shift_q << 8) | CW'(rx_data);

   always_comb begin
      rx_state_nxt = rx_state;
      byte_cnt_nxt = byte_cnt;
      tmo_cnt_nxt  = tmo_cnt;
      clr_rx_rdy   = 1'b0;
      fin          = 1'b0;
      tmo_hit      = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_rdy) begin
               clr_rx_rdy  = 1'b1;
               tmo_cnt_nxt = '0;
               if (FRAME_BYTES == 1) begin
                  fin          = 1'b1;
                  byte_cnt_nxt = '0;
               end else begin
                  byte_cnt_nxt = CNT_W'(1);
                  rx_state_nxt = RX_COLLECT;
               end
            end
         end
         RX_COLLECT: begin
            if (rx_rdy) begin
               clr_rx_rdy  = 1'b1;
               tmo_cnt_nxt = '0;
               if (byte_cnt == CNT_W'(FRAME_BYTES-1)) begin
                  fin          = 1'b1;
                  byte_cnt_nxt = '0;
                  rx_state_nxt = RX_IDLE;
               end else begin
                  byte_cnt_nxt = byte_cnt + CNT_W'(1);
               end
            end else if (TIMEOUT_CYC != 0) begin
               if (tmo_cnt == TMO_W'(TIMEOUT_CYC)) begin
                  tmo_hit      = 1'b1;
                  byte_cnt_nxt = '0;
                  tmo_cnt_nxt  = '0;
                  rx_state_nxt = RX_IDLE;
               end else begin
                  tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
               end
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

`ifdef UART_FRAME_CHKSUM_EN
   logic [7:0] chk_q, chk_sum;

   assign chk_sum = chk_add((rx_state == RX_IDLE) ? CHK_INIT : chk_q, rx_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_q <= CHK_INIT;
      end else if (rx_rdy) begin
         chk_q <= chk_sum;
      end
   end

   // the checksum byte itself is never shifted into cmd
   assign complete = fin & (chk_sum == 8'h00);
   assign chk_bad  = fin & (chk_sum != 8'h00);
   assign cmd_nxt  = shift_q;
`else
   assign complete = fin;
   assign chk_bad  = 1'b0;
   assign cmd_nxt  = shift_nxt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state  <= RX_IDLE;
         byte_cnt  <= '0;
         tmo_cnt   <= '0;
         shift_q   <= '0;
         cmd       <= '0;
         cmd_rdy   <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_state  <= rx_state_nxt;
         byte_cnt  <= byte_cnt_nxt;
         tmo_cnt   <= tmo_cnt_nxt;
         overrun   <= complete & cmd_rdy & ~clr_cmd_rdy;
         frame_err <= tmo_hit | chk_bad;
         if (rx_rdy) begin
            shift_q <= shift_nxt;
         end
         if (complete) begin
            cmd     <= cmd_nxt;
            cmd_rdy <= 1'b1;
         end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
         end
      end
   end

   resp_serializer #(
      .RESP_BYTES(RESP_BYTES)
   ) u_resp_serializer (
      .clk          (clk),
      .rst          (rst),
      .resp         (resp),
      .trmt         (trmt),
      .uart_tx_data (uart_tx_data),
      .uart_trmt    (uart_trmt),
      .uart_tx_done (uart_tx_done),
      .resp_busy    (resp_busy),
      .resp_done    (resp_done)
   );

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer: instance a (2-byte cmd, 2-byte resp, timeout 100)
// and instance b (3-byte cmd, 1-byte resp, no timeout).
module tb_uart_cmd_framer;

`ifdef UART_FRAME_CHKSUM_EN
   localparam int RX_EXTRA = 1;
   localparam int TX_EXTRA = 1;
`else
   localparam int RX_EXTRA = 0;
   localparam int TX_EXTRA = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0]  rx_data_a = '0, rx_data_b = '0;
   logic        rx_rdy_a = 0, rx_rdy_b = 0;
   logic        clr_rx_rdy_a, clr_rx_rdy_b;
   logic [15:0] cmd_a;
   logic [23:0] cmd_b;
   logic        cmd_rdy_a, cmd_rdy_b;
   logic        clr_cmd_rdy_a = 0, clr_cmd_rdy_b = 0;
   logic        overrun_a, overrun_b, frame_err_a, frame_err_b;
   logic [15:0] resp_a = '0;
   logic [7:0]  resp_b = '0;
   logic        trmt_a = 0, trmt_b = 0;
   logic [7:0]  uart_tx_data_a, uart_tx_data_b;
   logic        uart_trmt_a, uart_trmt_b;
   logic        uart_tx_done_a = 0, uart_tx_done_b = 0;
   logic        resp_busy_a, resp_busy_b, resp_done_a, resp_done_b;

   uart_cmd_framer #(.CMD_BYTES(2), .RESP_BYTES(2), .TIMEOUT_CYC(100), .TMO_W(24)) dut_a (
      .clk(clk), .rst(rst), .rx_data(rx_data_a), .rx_rdy(rx_rdy_a), .clr_rx_rdy(clr_rx_rdy_a),
      .cmd(cmd_a), .cmd_rdy(cmd_rdy_a), .clr_cmd_rdy(clr_cmd_rdy_a), .overrun(overrun_a),
      .frame_err(frame_err_a), .resp(resp_a), .trmt(trmt_a), .uart_tx_data(uart_tx_data_a),
      .uart_trmt(uart_trmt_a), .uart_tx_done(uart_tx_done_a), .resp_busy(resp_busy_a),
      .resp_done(resp_done_a));

   uart_cmd_framer #(.CMD_BYTES(3), .RESP_BYTES(1), .TIMEOUT_CYC(0), .TMO_W(24)) dut_b (
      .clk(clk), .rst(rst), .rx_data(rx_data_b), .rx_rdy(rx_rdy_b), .clr_rx_rdy(clr_rx_rdy_b),
      .cmd(cmd_b), .cmd_rdy(cmd_rdy_b), .clr_cmd_rdy(clr_cmd_rdy_b), .overrun(overrun_b),
      .frame_err(frame_err_b), .resp(resp_b), .trmt(trmt_b), .uart_tx_data(uart_tx_data_b),
      .uart_trmt(uart_trmt_b), .uart_tx_done(uart_tx_done_b), .resp_busy(resp_busy_b),
      .resp_done(resp_done_b));

   int total = 0;
   int bad = 0;

   int n_clr_a = 0, n_ovr_a = 0, n_fe_a = 0, n_trmt_a = 0, n_done_a = 0;
   int n_clr_b = 0, n_ovr_b = 0, n_fe_b = 0, n_trmt_b = 0, n_done_b = 0;

   always @(posedge clk) begin
      if (clr_rx_rdy_a) n_clr_a <= n_clr_a + 1;
      if (overrun_a)    n_ovr_a <= n_ovr_a + 1;
      if (frame_err_a)  n_fe_a  <= n_fe_a + 1;
      if (uart_trmt_a)  n_trmt_a <= n_trmt_a + 1;
      if (resp_done_a)  n_done_a <= n_done_a + 1;
      if (clr_rx_rdy_b) n_clr_b <= n_clr_b + 1;
      if (overrun_b)    n_ovr_b <= n_ovr_b + 1;
      if (frame_err_b)  n_fe_b  <= n_fe_b + 1;
      if (uart_trmt_b)  n_trmt_b <= n_trmt_b + 1;
      if (resp_done_b)  n_done_b <= n_done_b + 1;
   end

   task automatic send_a(input logic [7:0] b);
      @(negedge clk); rx_data_a = b; rx_rdy_a = 1'b1;
      @(negedge clk); rx_rdy_a = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      @(negedge clk); rx_data_b = b; rx_rdy_b = 1'b1;
      @(negedge clk); rx_rdy_b = 1'b0;
   endtask

   task automatic send_cmd_a(input logic [15:0] w);
      send_a(w[15:8]);
      send_a(w[7:0]);
`ifdef UART_FRAME_CHKSUM_EN
      send_a(8'h00 - w[15:8] - w[7:0]);
`endif
   endtask

   task automatic send_cmd_b(input logic [23:0] w);
      send_b(w[23:16]);
      send_b(w[15:8]);
      send_b(w[7:0]);
`ifdef UART_FRAME_CHKSUM_EN
      send_b(8'h00 - w[23:16] - w[15:8] - w[7:0]);
`endif
   endtask

   task automatic wait_trmt_a(output logic got, output logic [7:0] d);
      got = 1'b0; d = '0;
      for (int i = 0; i < 30; i++) begin
         if (uart_trmt_a) begin got = 1'b1; d = uart_tx_data_a; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_trmt_b(output logic got, output logic [7:0] d);
      got = 1'b0; d = '0;
      for (int i = 0; i < 30; i++) begin
         if (uart_trmt_b) begin got = 1'b1; d = uart_tx_data_b; break; end
         @(negedge clk);
      end
   endtask

   task automatic pulse_done_a();
      @(negedge clk); uart_tx_done_a = 1'b1;
      @(negedge clk); uart_tx_done_a = 1'b0;
   endtask

   task automatic pulse_done_b();
      @(negedge clk); uart_tx_done_b = 1'b1;
      @(negedge clk); uart_tx_done_b = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({cmd_rdy_a, clr_rx_rdy_a, overrun_a, frame_err_a, uart_trmt_a, resp_busy_a, resp_done_a} !== 7'b0) begin
         bad++; $display("FAIL reset_flags_a got=%b want=0000000",
            {cmd_rdy_a, clr_rx_rdy_a, overrun_a, frame_err_a, uart_trmt_a, resp_busy_a, resp_done_a});
      end
      total++;
      if (cmd_a !== 16'h0 || uart_tx_data_a !== 8'h0) begin
         bad++; $display("FAIL reset_data_a cmd=%h tx=%h want 0", cmd_a, uart_tx_data_a);
      end
      total++;
      if ({cmd_rdy_b, clr_rx_rdy_b, overrun_b, frame_err_b, uart_trmt_b, resp_busy_b, resp_done_b} !== 7'b0) begin
         bad++; $display("FAIL reset_flags_b got=%b want=0000000",
            {cmd_rdy_b, clr_rx_rdy_b, overrun_b, frame_err_b, uart_trmt_b, resp_busy_b, resp_done_b});
      end
      total++;
      if (cmd_b !== 24'h0 || uart_tx_data_b !== 8'h0) begin
         bad++; $display("FAIL reset_data_b cmd=%h tx=%h want 0", cmd_b, uart_tx_data_b);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_cmd2();
      int c0;
      c0 = n_clr_a;
      send_a(8'hA5);
      total++;
      if (cmd_rdy_a !== 1'b0) begin bad++; $display("FAIL cmd2_early_rdy got=%b want=0", cmd_rdy_a); end
      send_a(8'h3C);
`ifdef UART_FRAME_CHKSUM_EN
      send_a(8'h1F);
`endif
      total++;
      if (cmd_a !== 16'hA53C) begin bad++; $display("FAIL cmd2_value got=%h want=a53c", cmd_a); end
      total++;
      if (cmd_rdy_a !== 1'b1) begin bad++; $display("FAIL cmd2_rdy got=%b want=1", cmd_rdy_a); end
      total++;
      if (n_clr_a - c0 !== 2 + RX_EXTRA) begin
         bad++; $display("FAIL cmd2_clr_count got=%0d want=%0d", n_clr_a - c0, 2 + RX_EXTRA);
      end
      clr_cmd_rdy_a = 1'b1;
      @(negedge clk); clr_cmd_rdy_a = 1'b0;
      total++;
      if (cmd_rdy_a !== 1'b0) begin bad++; $display("FAIL cmd2_clear got=%b want=0", cmd_rdy_a); end
   endtask

   task automatic test_overrun();
      int o0;
      o0 = n_ovr_b;
      send_cmd_b(24'h123456);
      total++;
      if (cmd_b !== 24'h123456 || cmd_rdy_b !== 1'b1) begin
         bad++; $display("FAIL ovr_first got=%h/%b want=123456/1", cmd_b, cmd_rdy_b);
      end
      send_cmd_b(24'h9ABCDE);
      @(negedge clk);
      total++;
      if (cmd_b !== 24'h9ABCDE) begin bad++; $display("FAIL ovr_value got=%h want=9abcde", cmd_b); end
      total++;
      if (n_ovr_b - o0 !== 1) begin bad++; $display("FAIL ovr_count got=%0d want=1", n_ovr_b - o0); end
      total++;
      if (cmd_rdy_b !== 1'b1) begin bad++; $display("FAIL ovr_rdy got=%b want=1", cmd_rdy_b); end
      clr_cmd_rdy_b = 1'b1;
      @(negedge clk); clr_cmd_rdy_b = 1'b0;
      total++;
      if (cmd_rdy_b !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", cmd_rdy_b); end
   endtask

   task automatic test_timeout();
      int f0;
      f0 = n_fe_a;
      send_a(8'h11);
      repeat (90) @(negedge clk);
      total++;
      if (n_fe_a - f0 !== 0) begin bad++; $display("FAIL tmo_early got=%0d want=0", n_fe_a - f0); end
      repeat (30) @(negedge clk);
      total++;
      if (n_fe_a - f0 !== 1) begin bad++; $display("FAIL tmo_count got=%0d want=1", n_fe_a - f0); end
      total++;
      if (cmd_a !== 16'hA53C || cmd_rdy_a !== 1'b0) begin
         bad++; $display("FAIL tmo_keep got=%h/%b want=a53c/0", cmd_a, cmd_rdy_a);
      end
      send_cmd_a(16'hAABB);
      total++;
      if (cmd_a !== 16'hAABB || cmd_rdy_a !== 1'b1) begin
         bad++; $display("FAIL tmo_next got=%h/%b want=aabb/1", cmd_a, cmd_rdy_a);
      end
      clr_cmd_rdy_a = 1'b1;
      @(negedge clk); clr_cmd_rdy_a = 1'b0;
   endtask

   task automatic test_no_timeout();
      int f0;
      f0 = n_fe_b;
      send_b(8'h77);
      repeat (200) @(negedge clk);
      send_b(8'h88);
      send_b(8'h99);
`ifdef UART_FRAME_CHKSUM_EN
      send_b(8'h68);
`endif
      total++;
      if (n_fe_b - f0 !== 0) begin bad++; $display("FAIL notmo_err got=%0d want=0", n_fe_b - f0); end
      total++;
      if (cmd_b !== 24'h778899) begin bad++; $display("FAIL notmo_value got=%h want=778899", cmd_b); end
      clr_cmd_rdy_b = 1'b1;
      @(negedge clk); clr_cmd_rdy_b = 1'b0;
   endtask

   task automatic test_resp_a();
      int t0, d0;
      logic got;
      logic [7:0] d;
      t0 = n_trmt_a; d0 = n_done_a;
      @(negedge clk); resp_a = 16'hCAFE; trmt_a = 1'b1;
      @(negedge clk); trmt_a = 1'b0;
      total++;
      if (resp_busy_a !== 1'b1) begin bad++; $display("FAIL resp_busy got=%b want=1", resp_busy_a); end
      wait_trmt_a(got, d);
      total++;
      if (!got || d !== 8'hCA) begin bad++; $display("FAIL resp_byte0 seen=%b got=%h want=ca", got, d); end
      // retrigger and port change mid-transfer must both be ignored
      resp_a = 16'h1234; trmt_a = 1'b1;
      @(negedge clk); trmt_a = 1'b0;
      repeat (3) @(negedge clk);
      pulse_done_a();
      wait_trmt_a(got, d);
      total++;
      if (!got || d !== 8'hFE) begin bad++; $display("FAIL resp_byte1 seen=%b got=%h want=fe", got, d); end
`ifdef UART_FRAME_CHKSUM_EN
      pulse_done_a();
      wait_trmt_a(got, d);
      total++;
      if (!got || d !== 8'h38) begin bad++; $display("FAIL resp_chk seen=%b got=%h want=38", got, d); end
`endif
      total++;
      if (n_done_a - d0 !== 0) begin bad++; $display("FAIL resp_done_early got=%0d want=0", n_done_a - d0); end
      pulse_done_a();
      repeat (20) @(negedge clk);
      total++;
      if (n_done_a - d0 !== 1) begin bad++; $display("FAIL resp_done got=%0d want=1", n_done_a - d0); end
      total++;
      if (n_trmt_a - t0 !== 2 + TX_EXTRA) begin
         bad++; $display("FAIL resp_trmt_count got=%0d want=%0d", n_trmt_a - t0, 2 + TX_EXTRA);
      end
      total++;
      if (resp_busy_a !== 1'b0) begin bad++; $display("FAIL resp_idle got=%b want=0", resp_busy_a); end
   endtask

   task automatic test_resp_b();
      int d0;
      logic got;
      logic [7:0] d;
      d0 = n_done_b;
      @(negedge clk); resp_b = 8'h05; trmt_b = 1'b1;
      @(negedge clk); trmt_b = 1'b0;
      wait_trmt_b(got, d);
      total++;
      if (!got || d !== 8'h05) begin bad++; $display("FAIL respb_byte0 seen=%b got=%h want=05", got, d); end
`ifdef UART_FRAME_CHKSUM_EN
      pulse_done_b();
      wait_trmt_b(got, d);
      total++;
      if (!got || d !== 8'hFB) begin bad++; $display("FAIL respb_chk seen=%b got=%h want=fb", got, d); end
`endif
      pulse_done_b();
      repeat (5) @(negedge clk);
      total++;
      if (n_done_b - d0 !== 1 || resp_busy_b !== 1'b0) begin
         bad++; $display("FAIL respb_done got=%0d/%b want=1/0", n_done_b - d0, resp_busy_b);
      end
   endtask

   task automatic test_reset_midframe();
      int f0, d0;
      logic got;
      logic [7:0] d;
      f0 = n_fe_a; d0 = n_done_b;
      send_a(8'hEE);
      @(negedge clk); resp_b = 8'h5A; trmt_b = 1'b1;
      @(negedge clk); trmt_b = 1'b0;
      wait_trmt_b(got, d);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (cmd_a !== 16'h0 || resp_busy_b !== 1'b0) begin
         bad++; $display("FAIL midrst_clear cmd=%h busy=%b want=0000/0", cmd_a, resp_busy_b);
      end
      rst = 1'b0;
      @(negedge clk);
      send_cmd_a(16'h0102);
      repeat (10) @(negedge clk);
      total++;
      if (cmd_a !== 16'h0102 || cmd_rdy_a !== 1'b1) begin
         bad++; $display("FAIL midrst_value got=%h/%b want=0102/1", cmd_a, cmd_rdy_a);
      end
      total++;
      if (n_fe_a - f0 !== 0) begin bad++; $display("FAIL midrst_err got=%0d want=0", n_fe_a - f0); end
      total++;
      if (n_done_b - d0 !== 0) begin bad++; $display("FAIL midrst_resp_done got=%0d want=0", n_done_b - d0); end
      clr_cmd_rdy_a = 1'b1;
      @(negedge clk); clr_cmd_rdy_a = 1'b0;
   endtask

`ifdef UART_FRAME_CHKSUM_EN
   task automatic test_chksum();
      int f0;
      f0 = n_fe_a;
      send_a(8'h10); send_a(8'h20); send_a(8'hD0);
      total++;
      if (cmd_a !== 16'h1020 || cmd_rdy_a !== 1'b1) begin
         bad++; $display("FAIL chk_good got=%h/%b want=1020/1", cmd_a, cmd_rdy_a);
      end
      clr_cmd_rdy_a = 1'b1;
      @(negedge clk); clr_cmd_rdy_a = 1'b0;
      send_a(8'h10); send_a(8'h20); send_a(8'hD1);
      @(negedge clk);
      total++;
      if (n_fe_a - f0 !== 1) begin bad++; $display("FAIL chk_bad_err got=%0d want=1", n_fe_a - f0); end
      total++;
      if (cmd_a !== 16'h1020 || cmd_rdy_a !== 1'b0) begin
         bad++; $display("FAIL chk_bad_keep got=%h/%b want=1020/0", cmd_a, cmd_rdy_a);
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_cmd2();
      test_overrun();
      test_timeout();
      test_no_timeout();
      test_resp_a();
      test_resp_b();
      test_reset_midframe();
`ifdef UART_FRAME_CHKSUM_EN
      test_chksum();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
